// File: rtl/reg_file_sb.sv
// reg_file_sb
// Register file with a per-register pending (scoreboard) bit for the
// pipelined core. Decode reads two operands and their pending status through
// the combinational read ports. It marks a destination busy on issue.
// Writeback stores the result and clears the pending bit.
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst_n           synchronous active-low reset
//   raddr0/raddr1   read addresses
//   rdata0/rdata1   combinational read data (x0 reads as zero)
//   rbusy0/rbusy1   combinational pending status of the addressed register
//   iss_valid       an instruction with destination iss_addr issues this cycle
//   iss_addr        destination register of the issuing instruction
//   we/waddr/wdata  writeback port
//   nbusy           registered count of busy registers
//
// Build option
//   REG_FILE_BYPASS_EN  when defined, a read of the register being written
//                       back this cycle returns wdata and reports not-busy
//                       (unless the same register is re-issued this cycle).
//                       When undefined, reads see the pre-edge state.

module reg_file_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   raddr0,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata0,
  output logic [XLEN-1:0] rdata1,
  output logic            rbusy0,
  output logic            rbusy1,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_addr,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  output logic [AW:0]     nbusy
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      nbusy_q, nbusy_d;

  logic wr_ok;
  logic iss_ok;
  logic set_inc;
  logic clr_dec;

  // Writes and issues aimed at x0 are dropped here, so regs_q[0] and
  // busy_q[0] never leave their reset value of zero.
  assign wr_ok  = we && (waddr != '0);
  assign iss_ok = iss_valid && (iss_addr != '0);

  // nbusy moves by at most one per cycle. A register is counted in only when
  // it goes from idle to busy. It is counted out only when a busy register is
  // written back and not re-issued in the same cycle. Because each counter
  // step mirrors exactly one bit flip in busy_d, the count can never wrap.
  assign set_inc = iss_ok && !busy_q[iss_addr];
  assign clr_dec = wr_ok && busy_q[waddr] && !(iss_ok && (iss_addr == waddr));

  always_comb begin
    regs_d  = regs_q;
    busy_d  = busy_q;
    nbusy_d = nbusy_q;
    if (wr_ok) begin
      regs_d[waddr] = wdata;
      busy_d[waddr] = 1'b0;
    end
    // Issue is applied after writeback so a same-cycle issue wins.
    if (iss_ok) begin
      busy_d[iss_addr] = 1'b1;
    end
    nbusy_d = nbusy_q + {{AW{1'b0}}, set_inc} - {{AW{1'b0}}, clr_dec};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q  <= '0;
      nbusy_q <= '0;
    end else begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      nbusy_q <= nbusy_d;
    end
  end

  assign nbusy = nbusy_q;

  // Read port 0
  always_comb begin
    rdata0 = regs_q[raddr0];
    rbusy0 = busy_q[raddr0];
`ifdef REG_FILE_BYPASS_EN
    if (wr_ok && (waddr == raddr0)) begin
      rdata0 = wdata;
      rbusy0 = iss_ok && (iss_addr == raddr0);
    end
`endif
    if (raddr0 == '0) begin
      rdata0 = '0;
      rbusy0 = 1'b0;
    end
  end

  // Read port 1
  always_comb begin
    rdata1 = regs_q[raddr1];
    rbusy1 = busy_q[raddr1];
`ifdef REG_FILE_BYPASS_EN
    if (wr_ok && (waddr == raddr1)) begin
      rdata1 = wdata;
      rbusy1 = iss_ok && (iss_addr == raddr1);
    end
`endif
    if (raddr1 == '0) begin
      rdata1 = '0;
      rbusy1 = 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   raddr0, raddr1;
  logic [XLEN-1:0] rdata0, rdata1;
  logic            rbusy0, rbusy1;
  logic            iss_valid;
  logic [AW-1:0]   iss_addr;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wdata;
  logic [AW:0]     nbusy;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0]  mx [NREGS];
  logic [NREGS-1:0] mbusy;

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .raddr0(raddr0), .raddr1(raddr1),
    .rdata0(rdata0), .rdata1(rdata1),
    .rbusy0(rbusy0), .rbusy1(rbusy1),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .we(we), .waddr(waddr), .wdata(wdata),
    .nbusy(nbusy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iss_valid = 1'b0;
    iss_addr  = '0;
    we        = 1'b0;
    waddr     = '0;
    wdata     = '0;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, NREGS - 1));
  endfunction

  // Checks one read port against the bench model for the current inputs.
  task automatic chk_port(input string tag, input logic [AW-1:0] a,
                          input logic [XLEN-1:0] d, input logic b);
    logic [XLEN-1:0] ed;
    logic            eb;
    logic            check_b;
    ed = mx[a];
    eb = mbusy[a];
    check_b = 1'b1;
    if (a == '0) begin
      ed = '0;
      eb = 1'b0;
    end else if (BYP && we && (waddr == a)) begin
      ed = wdata;
      eb = 1'b0;
      if (iss_valid && (iss_addr == a)) check_b = 1'b0;
    end
    chk({tag, "_data"}, d, ed);
    if (check_b) chk({tag, "_busy"}, 32'(b), 32'(eb));
  endtask

  initial begin
    int expn;
    rst_n = 1'b0;
    raddr0 = '0;
    raddr1 = '0;
    idle_inputs();
    step();
    step();
    rst_n = 1'b1;

    // Reset state: every address reads zero and idle.
    for (int i = 0; i < NREGS; i++) begin
      raddr0 = AW'(i);
      raddr1 = AW'(NREGS - 1 - i);
      #1;
      chk("rst_rdata0", rdata0, 32'h0);
      chk("rst_rdata1", rdata1, 32'h0);
      chk("rst_rbusy0", 32'(rbusy0), 32'h0);
      chk("rst_rbusy1", 32'(rbusy1), 32'h0);
    end
    chk("rst_nbusy", 32'(nbusy), 32'h0);

    // x0 ignores writes and issues.
    we = 1'b1; waddr = 5'd0; wdata = 32'hDEADBEEF;
    iss_valid = 1'b1; iss_addr = 5'd0;
    step();
    idle_inputs();
    raddr0 = 5'd0;
    #1;
    chk("x0_rdata", rdata0, 32'h0);
    chk("x0_rbusy", 32'(rbusy0), 32'h0);
    chk("x0_nbusy", 32'(nbusy), 32'h0);

    // Preload x5 while idle: data stored, nbusy unchanged.
    we = 1'b1; waddr = 5'd5; wdata = 32'h11111111;
    step();
    idle_inputs();
    raddr0 = 5'd5;
    #1;
    chk("x5_pre_data", rdata0, 32'h11111111);
    chk("x5_pre_nbusy", 32'(nbusy), 32'h0);

    // Issue x5, writeback two cycles later.
    iss_valid = 1'b1; iss_addr = 5'd5;
    step();
    idle_inputs();
    chk("x5_iss_busy", 32'(rbusy0), 32'h1);
    chk("x5_iss_nbusy", 32'(nbusy), 32'h1);
    chk("x5_iss_data", rdata0, 32'h11111111);
    step();
    chk("x5_wait_busy", 32'(rbusy0), 32'h1);
    we = 1'b1; waddr = 5'd5; wdata = 32'h12345678;
    #1;
    chk("x5_wb_data", rdata0, BYP ? 32'h12345678 : 32'h11111111);
    chk("x5_wb_busy", 32'(rbusy0), BYP ? 32'h0 : 32'h1);
    step();
    idle_inputs();
    chk("x5_post_data", rdata0, 32'h12345678);
    chk("x5_post_busy", 32'(rbusy0), 32'h0);
    chk("x5_post_nbusy", 32'(nbusy), 32'h0);

    // Same-cycle issue and write to x7: data written, stays busy.
    iss_valid = 1'b1; iss_addr = 5'd7;
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
    step();
    idle_inputs();
    raddr1 = 5'd7;
    #1;
    chk("x7_data", rdata1, 32'hA5A5A5A5);
    chk("x7_busy", 32'(rbusy1), 32'h1);
    chk("x7_nbusy", 32'(nbusy), 32'h1);

    // Issue x3 twice: the second issue does not change the count.
    iss_valid = 1'b1; iss_addr = 5'd3;
    step();
    chk("x3_nbusy1", 32'(nbusy), 32'h2);
    step();
    idle_inputs();
    chk("x3_nbusy2", 32'(nbusy), 32'h2);

    // Write x9 while idle.
    we = 1'b1; waddr = 5'd9; wdata = 32'hCAFEF00D;
    step();
    idle_inputs();
    raddr0 = 5'd9;
    #1;
    chk("x9_data", rdata0, 32'hCAFEF00D);
    chk("x9_busy", 32'(rbusy0), 32'h0);
    chk("x9_nbusy", 32'(nbusy), 32'h2);

    // Issue x1..x31 back to back; x3 and x7 are already busy.
    for (int i = 1; i < NREGS; i++) begin
      iss_valid = 1'b1; iss_addr = AW'(i);
      step();
      expn = i + ((i < 3) ? 1 : 0) + ((i < 7) ? 1 : 0);
      chk("fill_nbusy", 32'(nbusy), 32'(expn));
    end
    iss_addr = 5'd31;
    step();
    idle_inputs();
    chk("full_nbusy", 32'(nbusy), 32'd31);
    raddr0 = 5'd31;
    raddr1 = 5'd0;
    #1;
    chk("full_rbusy31", 32'(rbusy0), 32'h1);
    chk("full_rbusy0", 32'(rbusy1), 32'h0);

    // Reset with a pending write to x4: everything cleared, write lost.
    rst_n = 1'b0;
    we = 1'b1; waddr = 5'd4; wdata = 32'hFFFFFFFF;
    step();
    rst_n = 1'b1;
    idle_inputs();
    raddr0 = 5'd4;
    raddr1 = 5'd9;
    #1;
    chk("rst2_nbusy", 32'(nbusy), 32'h0);
    chk("rst2_x4", rdata0, 32'h0);
    chk("rst2_x9", rdata1, 32'h0);
    chk("rst2_busy4", 32'(rbusy0), 32'h0);
    raddr0 = 5'd5;
    raddr1 = 5'd7;
    #1;
    chk("rst2_busy5", 32'(rbusy0), 32'h0);
    chk("rst2_busy7", 32'(rbusy1), 32'h0);

    // Random traffic against the bench model.
    for (int i = 0; i < NREGS; i++) mx[i] = '0;
    mbusy = '0;
    for (int c = 0; c < 10000; c++) begin
      iss_valid = 1'($urandom_range(0, 1));
      iss_addr  = rnd_addr();
      we        = 1'($urandom_range(0, 1));
      waddr     = rnd_addr();
      wdata     = $urandom();
      raddr0    = rnd_addr();
      raddr1    = rnd_addr();
      #1;
      chk_port("rnd_p0", raddr0, rdata0, rbusy0);
      chk_port("rnd_p1", raddr1, rdata1, rbusy1);
      step();
      if (we && waddr != '0) begin
        mx[waddr] = wdata;
        mbusy[waddr] = 1'b0;
      end
      if (iss_valid && iss_addr != '0) mbusy[iss_addr] = 1'b1;
      chk("rnd_nbusy", 32'(nbusy), 32'($countones(mbusy)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
